// File: rtl/me_pkg.sv
// Shared constants and geometry helpers for the motion-estimation search engine.
package me_pkg;

    // Search controller states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Search window edge in pixels
    function automatic int unsigned win_w(input int unsigned block, input int unsigned range);
        return block + 2 * range - 1;
    endfunction

    // SAD width: one pixel difference times BLOCK*BLOCK terms, never overflows
    function automatic int unsigned dist_w(input int unsigned block, input int unsigned pixel_w);
        return pixel_w + 2 * $clog2(block);
    endfunction

    // Signed motion component width, also the width of the biased offset counters
    function automatic int unsigned mv_w(input int unsigned range);
        return $clog2(range) + 1;
    endfunction

    // Reference ROM address width
    function automatic int unsigned addr_r_w(input int unsigned block);
        return $clog2(block * block);
    endfunction

    // Search ROM address width
    function automatic int unsigned addr_s_w(input int unsigned block, input int unsigned range);
        return $clog2(win_w(block, range) * win_w(block, range));
    endfunction

endpackage

// File: rtl/me_search_engine_if.sv
// ROM-side bus of the search engine: reference and search pixel fetch.
interface me_search_engine_if #(
    parameter int unsigned BLOCK   = 16,
    parameter int unsigned RANGE   = 8,
    parameter int unsigned PIXEL_W = 8
) ();
    import me_pkg::*;

    logic [addr_r_w(BLOCK)-1:0]        AddressR;
    logic [PIXEL_W-1:0]                R;
    logic [addr_s_w(BLOCK, RANGE)-1:0] AddressS;
    logic [PIXEL_W-1:0]                S;

    // Engine side issues addresses and receives pixels one cycle later
    modport master (output AddressR, output AddressS, input R, input S);

    // ROM side
    modport slave (input AddressR, input AddressS, output R, output S);

endinterface

// File: rtl/me_sad_accum.sv
// Absolute difference of one pixel pair plus running SAD accumulator.
module me_sad_accum #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned DIST_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [PIXEL_W-1:0] r,
    input  logic [PIXEL_W-1:0] s,
    output logic [DIST_W-1:0]  acc
);

    logic [PIXEL_W-1:0] diff_c;

    // Unsigned |r - s| without a sign bit
    always_comb begin
        diff_c = (r >= s) ? (r - s) : (s - r);
    end

    // Clear wins over enable so a discarded in-flight read never survives
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + DIST_W'(diff_c);
        end
    end

endmodule

// File: rtl/me_search_engine.sv
// Parametrised full-search block motion estimator with early exit options.
module me_search_engine
    import me_pkg::*;
#(
    parameter int unsigned BLOCK   = 16,
    parameter int unsigned RANGE   = 8,
    parameter int unsigned PIXEL_W = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  early_term_en,
    input  logic                                  thr_en,
    input  logic [dist_w(BLOCK, PIXEL_W)-1:0]     threshold,
    me_search_engine_if.master                    rom,
    output logic [dist_w(BLOCK, PIXEL_W)-1:0]     BestDist,
    output logic signed [mv_w(RANGE)-1:0]         motionX,
    output logic signed [mv_w(RANGE)-1:0]         motionY,
    output logic                                  busy,
    output logic                                  completed
);

    localparam int unsigned W      = win_w(BLOCK, RANGE);
    localparam int unsigned DIST_W = dist_w(BLOCK, PIXEL_W);
    localparam int unsigned MV_W   = mv_w(RANGE);
    localparam int unsigned AW_R   = addr_r_w(BLOCK);
    localparam int unsigned AW_S   = addr_s_w(BLOCK, RANGE);
    localparam int unsigned LB     = $clog2(BLOCK);

    localparam logic [AW_R-1:0] IDX_LAST = AW_R'(BLOCK * BLOCK - 1);
    localparam logic [AW_R-1:0] IDX_ONE  = AW_R'(1);
    localparam logic [MV_W-1:0] OFS_LAST = MV_W'(2 * RANGE - 1);
    localparam logic [MV_W-1:0] OFS_BIAS = MV_W'(RANGE);
    localparam logic [MV_W-1:0] OFS_ONE  = MV_W'(1);

    // Candidate offsets are kept biased by RANGE so they run 0..2*RANGE-1
    logic [2:0]              state_q, nxt_state;
    logic [AW_R-1:0]         idx_q, nxt_idx;
    logic [MV_W-1:0]         ox_q, nxt_ox;
    logic [MV_W-1:0]         oy_q, nxt_oy;
    logic [DIST_W-1:0]       nxt_best;
    logic signed [MV_W-1:0]  nxt_mvx, nxt_mvy;
    logic                    nxt_busy, nxt_done;
    logic                    et_q, nxt_et;
    logic                    thr_q, nxt_thr;
    logic [DIST_W-1:0]       thr_val_q, nxt_thr_val;
    logic                    rd_vld_q, nxt_rd_vld;
    logic [AW_R-1:0]         addr_r_q, nxt_addr_r;
    logic [AW_S-1:0]         addr_s_q, nxt_addr_s;

    logic                    acc_clr_c;
    logic                    upd_c;
    logic                    last_c;
    logic [DIST_W-1:0]       best_new_c;
    logic [LB-1:0]           row_c, col_c;
    logic [DIST_W-1:0]       acc;

    assign rom.AddressR = addr_r_q;
    assign rom.AddressS = addr_s_q;

    me_sad_accum #(
        .PIXEL_W (PIXEL_W),
        .DIST_W  (DIST_W)
    ) u_sad_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clr_c),
        .enable (rd_vld_q),
        .r      (rom.R),
        .s      (rom.S),
        .acc    (acc)
    );

    // Next-state, candidate scan, best tracking and address generation
    always_comb begin
        nxt_state   = state_q;
        nxt_idx     = idx_q;
        nxt_ox      = ox_q;
        nxt_oy      = oy_q;
        nxt_best    = BestDist;
        nxt_mvx     = motionX;
        nxt_mvy     = motionY;
        nxt_busy    = busy;
        nxt_done    = completed;
        nxt_et      = et_q;
        nxt_thr     = thr_q;
        nxt_thr_val = thr_val_q;
        nxt_rd_vld  = 1'b0;
        acc_clr_c   = 1'b0;
        upd_c       = (acc < BestDist);
        last_c      = (ox_q == OFS_LAST) && (oy_q == OFS_LAST);
        best_new_c  = upd_c ? acc : BestDist;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt_state   = ST_FETCH;
                    nxt_best    = '1;
                    nxt_ox      = '0;
                    nxt_oy      = '0;
                    nxt_idx     = '0;
                    nxt_et      = early_term_en;
                    nxt_thr     = thr_en;
                    nxt_thr_val = threshold;
                    nxt_busy    = 1'b1;
                    nxt_done    = 1'b0;
                    acc_clr_c   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (et_q && (acc >= BestDist)) begin
                    // Candidate cannot win any more; the read issued now is dropped
                    nxt_state = ST_COMPARE;
                end else begin
                    nxt_rd_vld = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        nxt_state = ST_DRAIN;
                    end else begin
                        nxt_idx = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                nxt_state = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (upd_c) begin
                    nxt_best = acc;
                    nxt_mvx  = ox_q - OFS_BIAS;
                    nxt_mvy  = oy_q - OFS_BIAS;
                end
                if (ox_q == OFS_LAST) begin
                    nxt_ox = '0;
                    nxt_oy = oy_q + OFS_ONE;
                end else begin
                    nxt_ox = ox_q + OFS_ONE;
                end
                nxt_idx   = '0;
                acc_clr_c = 1'b1;
                if (last_c || (thr_q && (best_new_c <= thr_val_q))) begin
                    nxt_state = ST_DONE;
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_state = ST_FETCH;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        row_c      = nxt_idx[AW_R-1:LB];
        col_c      = nxt_idx[LB-1:0];
        nxt_addr_r = nxt_idx;
        nxt_addr_s = AW_S'((32'(nxt_oy) + 32'(row_c)) * W + 32'(nxt_ox) + 32'(col_c));
    end

    // State and output registers; reset discards any search in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            BestDist  <= '1;
            motionX   <= '0;
            motionY   <= '0;
            busy      <= 1'b0;
            completed <= 1'b0;
            et_q      <= 1'b0;
            thr_q     <= 1'b0;
            thr_val_q <= '0;
            rd_vld_q  <= 1'b0;
            addr_r_q  <= '0;
            addr_s_q  <= '0;
        end else begin
            state_q   <= nxt_state;
            idx_q     <= nxt_idx;
            ox_q      <= nxt_ox;
            oy_q      <= nxt_oy;
            BestDist  <= nxt_best;
            motionX   <= nxt_mvx;
            motionY   <= nxt_mvy;
            busy      <= nxt_busy;
            completed <= nxt_done;
            et_q      <= nxt_et;
            thr_q     <= nxt_thr;
            thr_val_q <= nxt_thr_val;
            rd_vld_q  <= nxt_rd_vld;
            addr_r_q  <= nxt_addr_r;
            addr_s_q  <= nxt_addr_s;
        end
    end

endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench: small 4x4/+-2 engine for behaviour, default engine for full-size timing.
module tb_me_search_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        early_term_en;
    logic        thr_en;

    // Small instance: BLOCK=4, RANGE=2, W=7, DIST_W=12, MV_W=2
    logic              start_s;
    logic [11:0]       thr_val_s;
    logic [11:0]       best_s;
    logic signed [1:0] mx_s, my_s;
    logic              busy_s, completed_s;

    // Default instance: BLOCK=16, RANGE=8, DIST_W=16, MV_W=4
    logic              start_d;
    logic [15:0]       thr_val_d;
    logic [15:0]       best_d;
    logic signed [3:0] mx_d, my_d;
    logic              busy_d, completed_d;

    me_search_engine_if #(.BLOCK(4), .RANGE(2), .PIXEL_W(8)) bus_s ();
    me_search_engine_if #(.BLOCK(16), .RANGE(8), .PIXEL_W(8)) bus_d ();

    me_search_engine #(.BLOCK(4), .RANGE(2), .PIXEL_W(8)) dut_s (
        .clock         (clock),
        .reset         (reset),
        .start         (start_s),
        .early_term_en (early_term_en),
        .thr_en        (thr_en),
        .threshold     (thr_val_s),
        .rom           (bus_s),
        .BestDist      (best_s),
        .motionX       (mx_s),
        .motionY       (my_s),
        .busy          (busy_s),
        .completed     (completed_s)
    );

    me_search_engine #(.BLOCK(16), .RANGE(8), .PIXEL_W(8)) dut_d (
        .clock         (clock),
        .reset         (reset),
        .start         (start_d),
        .early_term_en (1'b0),
        .thr_en        (1'b0),
        .threshold     (thr_val_d),
        .rom           (bus_d),
        .BestDist      (best_d),
        .motionX       (mx_d),
        .motionY       (my_d),
        .busy          (busy_d),
        .completed     (completed_d)
    );

    // Synchronous ROM models
    logic [7:0] r_mem [0:15];
    logic [7:0] s_mem [0:48];

    always @(posedge clock) begin
        bus_s.R <= r_mem[bus_s.AddressR];
        bus_s.S <= s_mem[bus_s.AddressS];
        bus_d.R <= 8'h10;
        bus_d.S <= 8'h00;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int absd(input int ox, input int oy, input int p);
        int a, b;
        a = int'(r_mem[p]);
        b = int'(s_mem[(oy + p / 4) * 7 + ox + p % 4]);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int sad(input int ox, input int oy);
        int sum;
        sum = 0;
        for (int p = 0; p < 16; p++) sum += absd(ox, oy, p);
        return sum;
    endfunction

    // Reference for early termination: partial SAD seen in fetch cycle k covers pixels 0..k-2
    task automatic model_et(output int best, output int cyc, output int mx, output int my);
        int acc, k_abort;
        best = 4095; cyc = 0; mx = 0; my = 0;
        for (int oy = 0; oy < 4; oy++) begin
            for (int ox = 0; ox < 4; ox++) begin
                acc = 0;
                k_abort = -1;
                for (int k = 0; k < 16; k++) begin
                    if (acc >= best) begin
                        k_abort = k;
                        break;
                    end
                    if (k >= 1) acc += absd(ox, oy, k - 1);
                end
                if (k_abort >= 0) begin
                    cyc += k_abort + 2;
                end else begin
                    cyc += 18;
                    if (sad(ox, oy) < best) begin
                        best = sad(ox, oy);
                        mx = ox - 2;
                        my = oy - 2;
                    end
                end
            end
        end
    endtask

    // Pseudo-random window, reference block copied from offset dx=1, dy=-2
    task automatic load_scan1();
        for (int a = 0; a < 49; a++) s_mem[a] = 8'((a * a * 7 + a * 31 + 3) % 251);
        for (int p = 0; p < 16; p++) r_mem[p] = s_mem[(p / 4) * 7 + 3 + p % 4];
    endtask

    // Window constant along (x-2y): exact matches only at (-1,-1) and (1,0)
    task automatic load_tie();
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++)
                s_mem[y * 7 + x] = 8'((x - 2 * y + 12) * 13 + 7);
        for (int p = 0; p < 16; p++) r_mem[p] = s_mem[(1 + p / 4) * 7 + 1 + p % 4];
    endtask

    // Start the small engine and count edges until completed; optional stray start mid-search
    task automatic run_s(input int pulse_at, output int cycles);
        start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0;
        check_eq("busy_after_start", busy_s, 1);
        check_eq("completed_after_start", completed_s, 0);
        cycles = 0;
        while (!completed_s && cycles < 2000) begin
            start_s = (cycles == pulse_at);
            @(posedge clock); #1;
            cycles++;
        end
        start_s = 1'b0;
        check_eq("busy_at_done", busy_s, 0);
    endtask

    int cyc, m_best, m_cyc, m_mx, m_my, sad00;

    initial begin
        reset = 1'b1;
        start_s = 1'b0;
        start_d = 1'b0;
        early_term_en = 1'b0;
        thr_en = 1'b0;
        thr_val_s = '0;
        thr_val_d = '0;
        load_scan1();

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_best", best_s, 4095);
        check_eq("rst_mx", mx_s, 0);
        check_eq("rst_my", my_s, 0);
        check_eq("rst_busy", busy_s, 0);
        check_eq("rst_completed", completed_s, 0);
        check_eq("rst_addr_r", bus_s.AddressR, 0);
        check_eq("rst_addr_s", bus_s.AddressS, 0);
        check_eq("rst_best_default", best_d, 65535);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("idle_completed", completed_s, 0);

        // Full search, exact match at (1,-2)
        run_s(-1, cyc);
        check_eq("full_cycles", cyc, 288);
        check_eq("full_best", best_s, 0);
        check_eq("full_mx", mx_s, 1);
        check_eq("full_my", my_s, -2);
        repeat (5) @(posedge clock);
        #1;
        check_eq("done_hold_completed", completed_s, 1);
        check_eq("done_hold_best", best_s, 0);

        // Threshold 0: exit at the exact match, candidate index 3
        thr_en = 1'b1;
        thr_val_s = 12'd0;
        run_s(-1, cyc);
        check_eq("thr0_cycles", cyc, 72);
        check_eq("thr0_best", best_s, 0);
        check_eq("thr0_mx", mx_s, 1);
        check_eq("thr0_my", my_s, -2);

        // Threshold equal to first candidate SAD: inclusive compare exits after one candidate
        sad00 = sad(0, 0);
        thr_val_s = 12'(sad00);
        run_s(-1, cyc);
        check_eq("thr_eq_cycles", cyc, 18);
        check_eq("thr_eq_best", best_s, sad00);
        check_eq("thr_eq_mx", mx_s, -2);
        check_eq("thr_eq_my", my_s, -2);
        thr_en = 1'b0;

        // Early candidate termination
        early_term_en = 1'b1;
        model_et(m_best, m_cyc, m_mx, m_my);
        run_s(-1, cyc);
        check_eq("et_cycles", cyc, m_cyc);
        check_eq("et_faster", (cyc < 288), 1);
        check_eq("et_best", best_s, 0);
        check_eq("et_mx", mx_s, 1);
        check_eq("et_my", my_s, -2);
        early_term_en = 1'b0;

        // Tie between two exact matches; stray start while busy is ignored
        load_tie();
        run_s(100, cyc);
        check_eq("tie_cycles", cyc, 288);
        check_eq("tie_best", best_s, 0);
        check_eq("tie_mx", mx_s, -1);
        check_eq("tie_my", my_s, -1);

        // Reset during fetch of candidate 5, then a clean search
        load_scan1();
        start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0;
        repeat (95) @(posedge clock);
        #1;
        check_eq("mid_busy", busy_s, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("abort_busy", busy_s, 0);
        check_eq("abort_completed", completed_s, 0);
        check_eq("abort_best", best_s, 4095);
        check_eq("abort_mx", mx_s, 0);
        run_s(-1, cyc);
        check_eq("after_abort_cycles", cyc, 288);
        check_eq("after_abort_best", best_s, 0);
        check_eq("after_abort_mx", mx_s, 1);
        check_eq("after_abort_my", my_s, -2);

        // Default geometry, constant difference of 0x10 per pixel
        start_d = 1'b1;
        @(posedge clock); #1;
        start_d = 1'b0;
        check_eq("def_busy", busy_d, 1);
        cyc = 0;
        while (!completed_d && cyc < 70000) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_eq("def_cycles", cyc, 66048);
        check_eq("def_best", best_d, 4096);
        check_eq("def_mx", mx_d, -8);
        check_eq("def_my", my_d, -8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
